// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem issue/writeback path: result tag layout,
// load FSM states and the instruction routing class.
package fpu_ss_pkg;

  localparam int FPU_SS_ID_W = 4;

  typedef struct packed {
    logic                   rd_is_fp;
    logic [4:0]             rd;
    logic [FPU_SS_ID_W-1:0] id;
  } fpu_tag_t;

  typedef enum logic {
    IDLE,
    WAIT_RSP
  } ld_state_e;

  typedef enum logic [1:0] {
    CLS_FPU,
    CLS_LOAD,
    CLS_STORE,
    CLS_DROP
  } instr_cls_e;

  // FPU use takes precedence over memory flags; anything unflagged is dropped.
  function automatic instr_cls_e classify(logic use_fpu, logic is_load, logic is_store);
    if (use_fpu)       return CLS_FPU;
    else if (is_load)  return CLS_LOAD;
    else if (is_store) return CLS_STORE;
    else               return CLS_DROP;
  endfunction

endpackage

// File: rtl/fpu_ss_issue_ctrl_if.sv
// Decoder, fpnew, memory and writeback signals of the issue controller.
// slave = controller side, master = surrounding subsystem / testbench.
interface fpu_ss_issue_ctrl_if #(
  parameter int ID_WIDTH = 4
);
  localparam int TAG_W = 6 + ID_WIDTH;

  logic                in_valid_i;
  logic                in_ready_o;
  logic [ID_WIDTH-1:0] in_id_i;
  logic                in_use_fpu_i;
  logic                in_is_load_i;
  logic                in_is_store_i;
  logic                in_rd_is_fp_i;
  logic [2:0]          in_rs_used_i;
  logic [14:0]         in_rs_addr_i;
  logic [4:0]          in_rd_i;

  logic                fpu_in_valid_o;
  logic                fpu_in_ready_i;
  logic [TAG_W-1:0]    fpu_in_tag_o;
  logic                fpu_out_valid_i;
  logic                fpu_out_ready_o;
  logic [TAG_W-1:0]    fpu_out_tag_i;

  logic                mem_req_valid_o;
  logic                mem_req_ready_i;
  logic                mem_rsp_valid_i;

  logic                fpr_we_o;
  logic [4:0]          fpr_waddr_o;
  logic                fpr_wsel_o;

  logic                int_wb_valid_o;
  logic                int_wb_ready_i;
  logic [ID_WIDTH-1:0] int_wb_id_o;

  logic                busy_o;

  modport slave (
    input  in_valid_i, in_id_i, in_use_fpu_i, in_is_load_i, in_is_store_i,
           in_rd_is_fp_i, in_rs_used_i, in_rs_addr_i, in_rd_i,
           fpu_in_ready_i, fpu_out_valid_i, fpu_out_tag_i,
           mem_req_ready_i, mem_rsp_valid_i, int_wb_ready_i,
    output in_ready_o, fpu_in_valid_o, fpu_in_tag_o, fpu_out_ready_o,
           mem_req_valid_o, fpr_we_o, fpr_waddr_o, fpr_wsel_o,
           int_wb_valid_o, int_wb_id_o, busy_o
  );

  modport master (
    output in_valid_i, in_id_i, in_use_fpu_i, in_is_load_i, in_is_store_i,
           in_rd_is_fp_i, in_rs_used_i, in_rs_addr_i, in_rd_i,
           fpu_in_ready_i, fpu_out_valid_i, fpu_out_tag_i,
           mem_req_ready_i, mem_rsp_valid_i, int_wb_ready_i,
    input  in_ready_o, fpu_in_valid_o, fpu_in_tag_o, fpu_out_ready_o,
           mem_req_valid_o, fpr_we_o, fpr_waddr_o, fpr_wsel_o,
           int_wb_valid_o, int_wb_id_o, busy_o
  );

endinterface

// File: rtl/fpu_ss_scoreboard.sv
// Busy vector of pending FPR destinations: one set port, one clear port,
// three source read ports and a destination (WAW) check port.
module fpu_ss_scoreboard (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        set_en_i,
  input  logic [4:0]  set_addr_i,
  input  logic        clr_en_i,
  input  logic [4:0]  clr_addr_i,
  input  logic [14:0] rs_addr_i,
  output logic [2:0]  rs_busy_o,
  input  logic [4:0]  rd_chk_addr_i,
  output logic        rd_busy_o,
  output logic        any_busy_o
);

  logic [31:0] r_busy;
  logic [31:0] w_busy_nxt;

  // NOTE: every always_comb output gets a default first, otherwise paths that
  // skip an assignment infer a latch.
  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_en_i) w_busy_nxt[clr_addr_i] = 1'b0;
    if (set_en_i) w_busy_nxt[set_addr_i] = 1'b1;
  end

  // NOTE: the vector is plain flops, not RAM, so it is cleared by reset like
  // any other state; a stale bit after reset would stall issue forever.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  assign rs_busy_o[0] = r_busy[rs_addr_i[4:0]];
  assign rs_busy_o[1] = r_busy[rs_addr_i[9:5]];
  assign rs_busy_o[2] = r_busy[rs_addr_i[14:10]];
  assign rd_busy_o    = r_busy[rd_chk_addr_i];
  assign any_busy_o   = |r_busy;

endmodule

// File: rtl/fpu_ss_issue_ctrl.sv
// Issue and writeback controller: hazard-checked zero-latency issue to fpnew or
// memory, inflight tracking, and load-first arbitration of the FPR write port.
module fpu_ss_issue_ctrl
  import fpu_ss_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int ID_WIDTH     = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  fpu_ss_issue_ctrl_if.slave bus
);

  localparam int TAG_W = 6 + ID_WIDTH;
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  logic [CNT_W-1:0] r_inflight;
  ld_state_e        r_ld_state;
  ld_state_e        w_ld_state_nxt;
  logic [4:0]       r_ld_rd;

  logic [2:0]  w_rs_busy;
  logic        w_rd_busy;
  logic        w_sb_any;
  logic        w_hazard;
  logic        w_store_hz;
  logic        w_slot_free;
  instr_cls_e  w_cls;
  logic        w_fpu_in_valid;
  logic        w_mem_req_valid;
  logic        w_in_ready;
  logic        w_fpu_issue;
  logic        w_ld_issue;
  logic        w_out_rd_is_fp;
  logic [4:0]  w_out_rd;
  logic        w_ld_wb;
  logic        w_fpu_wb;
  logic        w_fpr_we;
  logic [4:0]  w_fpr_waddr;
  logic        w_fpu_out_ready;
  logic        w_fpu_ret;

  assign w_cls       = classify(bus.in_use_fpu_i, bus.in_is_load_i, bus.in_is_store_i);
  assign w_hazard    = (|(bus.in_rs_used_i & w_rs_busy)) | (bus.in_rd_is_fp_i & w_rd_busy);
  assign w_store_hz  = bus.in_rs_used_i[1] & w_rs_busy[1];
  assign w_slot_free = (r_inflight < MAX_CNT);

  always_comb begin
    w_fpu_in_valid  = 1'b0;
    w_mem_req_valid = 1'b0;
    w_in_ready      = 1'b0;
    if (!rst_i) begin
      unique case (w_cls)
        CLS_FPU: begin
          w_fpu_in_valid = bus.in_valid_i & ~w_hazard & w_slot_free;
          w_in_ready     = w_fpu_in_valid & bus.fpu_in_ready_i;
        end
        CLS_LOAD: begin
          w_mem_req_valid = bus.in_valid_i & ~w_hazard & (r_ld_state == IDLE);
          w_in_ready      = w_mem_req_valid & bus.mem_req_ready_i;
        end
        CLS_STORE: begin
          w_mem_req_valid = bus.in_valid_i & ~w_store_hz;
          w_in_ready      = w_mem_req_valid & bus.mem_req_ready_i;
        end
        default: w_in_ready = 1'b1;
      endcase
    end
  end

  assign w_fpu_issue = w_fpu_in_valid & bus.fpu_in_ready_i;
  assign w_ld_issue  = (w_cls == CLS_LOAD) & w_mem_req_valid & bus.mem_req_ready_i;

  // Writeback: a load response owns the port; an FPR-bound FPU result waits.
  assign w_out_rd_is_fp  = bus.fpu_out_tag_i[TAG_W-1];
  assign w_out_rd        = bus.fpu_out_tag_i[TAG_W-2 -: 5];
  assign w_ld_wb         = ~rst_i & (r_ld_state == WAIT_RSP) & bus.mem_rsp_valid_i;
  assign w_fpu_wb        = ~rst_i & bus.fpu_out_valid_i & w_out_rd_is_fp & ~w_ld_wb;
  assign w_fpr_we        = w_ld_wb | w_fpu_wb;
  assign w_fpr_waddr     = w_ld_wb ? r_ld_rd : w_out_rd;
  assign w_fpu_out_ready = ~rst_i & (w_out_rd_is_fp ? ~w_ld_wb : bus.int_wb_ready_i);
  assign w_fpu_ret       = bus.fpu_out_valid_i & w_fpu_out_ready;

  fpu_ss_scoreboard u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .set_en_i      ((w_fpu_issue | w_ld_issue) & bus.in_rd_is_fp_i),
    .set_addr_i    (bus.in_rd_i),
    .clr_en_i      (w_fpr_we),
    .clr_addr_i    (w_fpr_waddr),
    .rs_addr_i     (bus.in_rs_addr_i),
    .rs_busy_o     (w_rs_busy),
    .rd_chk_addr_i (bus.in_rd_i),
    .rd_busy_o     (w_rd_busy),
    .any_busy_o    (w_sb_any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= '0;
    end else if (w_fpu_issue && !w_fpu_ret) begin
      r_inflight <= r_inflight + CNT_W'(1);
    end else if (!w_fpu_issue && w_fpu_ret && r_inflight != '0) begin
      r_inflight <= r_inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ld_state <= IDLE;
      r_ld_rd    <= '0;
    end else begin
      r_ld_state <= w_ld_state_nxt;
      if (w_ld_issue) r_ld_rd <= bus.in_rd_i;
    end
  end

  always_comb begin
    w_ld_state_nxt = r_ld_state;
    unique case (r_ld_state)
      IDLE:     if (w_ld_issue)          w_ld_state_nxt = WAIT_RSP;
      WAIT_RSP: if (bus.mem_rsp_valid_i) w_ld_state_nxt = IDLE;
      default:                           w_ld_state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready_o      = w_in_ready;
  assign bus.fpu_in_valid_o  = w_fpu_in_valid;
  assign bus.fpu_in_tag_o    = {bus.in_rd_is_fp_i, bus.in_rd_i, bus.in_id_i};
  assign bus.mem_req_valid_o = w_mem_req_valid;
  assign bus.fpu_out_ready_o = w_fpu_out_ready;
  assign bus.fpr_we_o        = w_fpr_we;
  assign bus.fpr_waddr_o     = w_fpr_waddr;
  assign bus.fpr_wsel_o      = w_ld_wb;
  assign bus.int_wb_valid_o  = ~rst_i & bus.fpu_out_valid_i & ~w_out_rd_is_fp;
  assign bus.int_wb_id_o     = bus.fpu_out_tag_i[ID_WIDTH-1:0];
  assign bus.busy_o          = ~rst_i & ((r_inflight != '0) | (r_ld_state != IDLE) | w_sb_any);

endmodule

// File: doc/fpu_ss_issue_ctrl.md
# fpu_ss_issue_ctrl

Issue and writeback controller for the FPU subsystem. Sits between the instruction decoder and the fpnew core and memory interface. It accepts one decoded instruction per cycle and blocks it on FPR data hazards or resource limits. It routes the instruction to the FPU or the memory path, tracks outstanding operations, and arbitrates FPU results against load responses for the single FPR write port.

## Interface
Parameters:
- MAX_INFLIGHT, 4, max FPU operations issued but not yet returned (1..15)
- ID_WIDTH, 4, width of the offload instruction id

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- in_valid_i / in_ready_o  in/out  1  decoded-instruction handshake
- in_id_i  in  ID_WIDTH  instruction id
- in_use_fpu_i, in_is_load_i, in_is_store_i, in_rd_is_fp_i  in  1 each  decoder flags
- in_rs_used_i  in  3  bit k set: rs(k+1) is read from the FPR file
- in_rs_addr_i  in  15  rs1 [4:0], rs2 [9:5], rs3 [14:10]
- in_rd_i  in  5  destination register
- fpu_in_valid_o / fpu_in_ready_i  out/in  1  fpnew input handshake
- fpu_in_tag_o  out  TAG_W  {rd_is_fp, rd, id}; TAG_W = 6+ID_WIDTH
- fpu_out_valid_i / fpu_out_ready_o  in/out  1  fpnew result handshake
- fpu_out_tag_i  in  TAG_W  returned tag
- mem_req_valid_o / mem_req_ready_i  out/in  1  load/store request handshake
- mem_rsp_valid_i  in  1  load data valid; cannot be back-pressured
- fpr_we_o, fpr_waddr_o (5), fpr_wsel_o (0 = FPU, 1 = memory)  out  FPR write port control
- int_wb_valid_o / int_wb_ready_i  out/in  1  integer-destination result handshake
- int_wb_id_o  out  ID_WIDTH  id of the integer result
- busy_o  out  1  any FPU op, load or FPR write outstanding

## Operation
- Scoreboard: a 32-bit busy vector of FPR destinations.
  - A bit is set on the issue handshake when rd_is_fp.
  - A bit is cleared on FPR writeback.
  - Only registered state is used; there is no same-cycle bypass.
- Hazard: stall when any used rs is busy, or when in_rd_is_fp_i and rd is busy (WAW).
- FPU op (in_use_fpu_i):
  - fpu_in_valid_o = in_valid_i & no hazard & inflight < MAX_INFLIGHT.
  - in_ready_o = that condition & fpu_in_ready_i.
- Load:
  - Also requires load FSM in IDLE.
  - Drives mem_req_valid_o; ready follows mem_req_ready_i.
  - On handshake, latches rd and moves to WAIT_RSP.
- Store: needs rs2 (in_rs_used_i[1]) not busy. Completes on the mem_req handshake; no scoreboard entry.
- Anything else: accepted immediately (in_ready_o = 1) and dropped; no side effects.
- Load FSM:
  - IDLE → WAIT_RSP on load handshake.
  - WAIT_RSP → IDLE on mem_rsp_valid_i.
  - A response in IDLE is ignored.
- FPU result with tag.rd_is_fp = 1: writes FPR fpu_out_tag_i.rd.
  - fpu_out_ready_o = !(load FSM in WAIT_RSP & mem_rsp_valid_i).
- FPU result with tag.rd_is_fp = 0: presented on int_wb_valid_o with int_wb_id_o = tag.id.
  - fpu_out_ready_o = int_wb_ready_i.
- Writeback priority: a load response always wins the FPR port; the FPU result is held that cycle.
- Inflight counter:
  - +1 on the fpu_in handshake, −1 on the fpu_out handshake.
  - Both in the same cycle: unchanged.
- busy_o = inflight ≠ 0 | FSM ≠ IDLE | |scoreboard.

## Timing
- Issue is combinational, valid to valid/ready: zero latency, no registered stage.
- Writeback is combinational from fpu_out_valid_i / mem_rsp_valid_i. The scoreboard bit clears at the same edge as the write.
- An instruction stalled on rd X can issue at the earliest in the cycle after X's writeback.
- Reset values: scoreboard 0, inflight 0, FSM IDLE, busy_o 0.
  - fpu_in_valid_o, mem_req_valid_o, fpr_we_o and int_wb_valid_o are 0 during reset.
  - in_ready_o is 0 during reset.
- Reset mid-operation drops all tracking; responses arriving after reset are not written.
- Inflight = MAX_INFLIGHT with a simultaneous return: issue is still blocked that cycle (the check uses the registered count).

## Structure
- fpu_ss_pkg gains:
  - fpu_tag_t struct {rd_is_fp, rd[4:0], id}
  - ld_state_e {IDLE, WAIT_RSP}
- Sub-module fpu_ss_scoreboard: 32-bit busy vector with a set port, a clear port and three read ports, plus a rd-check port.

## Test plan
- FADD f3 issued, result returned 3 cycles later → FPR write f3 (fpr_wsel_o = 0); busy bit 3 set for exactly those cycles.
- FMUL f4 in flight, then FADD reading f4 → in_ready_o = 0 until the cycle after f4 writeback.
- MAX_INFLIGHT = 4 independent FADDs issued back-to-back, fifth offered → 5th stalls until the first result handshake.
- FPU result for f5 and load response for f6 in the same cycle → f6 written, fpu_out_ready_o = 0; f5 written next cycle.
- FEQ with int_wb_ready_i low for 2 cycles → int_wb_valid_o held, id stable, no FPR write.
- rst_i asserted while a load is in WAIT_RSP → FSM IDLE, busy_o = 0; a late mem_rsp_valid_i produces no fpr_we_o.
